// File: rtl/tcu_job_scheduler.sv
// tcu_job_scheduler: round-robin owner of one shared TCU. A granted requester
// streams DEPTH_INPUT operand words in, the TCU computes for COMPUTE_DEPTH+1
// cycles, DEPTH_OUTPUT result words are routed back to the owner, and a
// one-cycle done pulse ends the job.
// Optional build macro TCU_SCHED_TIMEOUT_EN adds a stall watchdog and an err port.
module tcu_job_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int DEPTH_INPUT   = 48,
  parameter int COMPUTE_DEPTH = 32,
  parameter int DEPTH_OUTPUT  = 16,
`ifdef TCU_SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 256,
`endif
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tcu_val_input,
  output logic [DATA_W-1:0]         tcu_data,
  input  logic                      tcu_shift_out,
  input  logic [DATA_W-1:0]         tcu_out_data,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic [NUM_REQ-1:0]        done,
`ifdef TCU_SCHED_TIMEOUT_EN
  output logic                      err,
`endif
  output logic                      busy
);

  localparam int IN_W  = $clog2(DEPTH_INPUT + 1);
  localparam int CMP_W = $clog2(COMPUTE_DEPTH + 1);
  localparam int OUT_W = $clog2(DEPTH_OUTPUT + 1);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(DEPTH_INPUT - 1);
  localparam logic [CMP_W-1:0] CMP_LAST = CMP_W'(COMPUTE_DEPTH);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(DEPTH_OUTPUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [IN_W-1:0]    in_cnt_q;
  logic [CMP_W-1:0]   cmp_cnt_q;
  logic [OUT_W-1:0]   out_cnt_q;

  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    cand;
  logic               owner_valid;
  logic [DATA_W-1:0]  owner_data;
  logic               load_last;
  logic               drain_last;
  logic               timeout_hit;

  assign owner_valid = req_valid[owner_q];
  assign owner_data  = req_data[int'(owner_q)*DATA_W +: DATA_W];
  assign load_last   = (state_q == LOAD) && owner_valid && (in_cnt_q == IN_LAST);
  assign drain_last  = (state_q == DRAIN) && tcu_shift_out && (out_cnt_q == OUT_LAST);
  assign grant       = grant_q;

`ifdef TCU_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;
  logic            stall;

  assign stall       = ((state_q == LOAD) && !owner_valid) ||
                       ((state_q == DRAIN) && !tcu_shift_out);
  assign timeout_hit = stall && (wd_cnt_q == WD_LAST);
  assign err         = (state_q == DONE) && err_q;

  // Watchdog: count consecutive stalled cycles; remember a timeout for the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (stall && !timeout_hit) ? wd_cnt_q + 1'b1 : '0;
      if (timeout_hit)
        err_q <= 1'b1;
      else if (state_q == DONE)
        err_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Round-robin pick: scan requesters starting just after the last owner.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and owner-routed outputs.
  always_comb begin
    state_d       = state_q;
    tcu_val_input = 1'b0;
    tcu_data      = '0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    resp_id       = '0;
    done          = '0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE:    if (pick_vld) state_d = LOAD;
      LOAD: begin
        tcu_val_input = owner_valid;
        tcu_data      = owner_data;
        if (load_last) state_d = COMPUTE;
      end
      COMPUTE: if (cmp_cnt_q == CMP_LAST) state_d = DRAIN;
      DRAIN: begin
        resp_valid = tcu_shift_out;
        resp_data  = tcu_out_data;
        resp_id    = owner_q;
        if (drain_last) state_d = DONE;
      end
      DONE: begin
        done    = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = DONE;
  end

  // Grant/owner latch, round-robin pointer and the per-phase counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
      in_cnt_q  <= '0;
      cmp_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        grant_q  <= NUM_REQ'(1) << pick_idx;
        owner_q  <= pick_idx;
        rr_ptr_q <= pick_idx;
      end else if (state_q == DONE) begin
        grant_q <= '0;
      end

      if (state_q == LOAD && (load_last || timeout_hit))
        in_cnt_q <= '0;
      else if (state_q == LOAD && owner_valid)
        in_cnt_q <= in_cnt_q + 1'b1;

      if (state_q == COMPUTE)
        cmp_cnt_q <= (cmp_cnt_q == CMP_LAST) ? '0 : cmp_cnt_q + 1'b1;

      if (state_q == DRAIN && (drain_last || timeout_hit))
        out_cnt_q <= '0;
      else if (state_q == DRAIN && tcu_shift_out)
        out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_tcu_job_scheduler.sv
// Self-checking bench for tcu_job_scheduler (default build, no watchdog).
// A table of job records plus randomized jobs is checked cycle by cycle
// against a job-level model: owner chosen by round-robin arithmetic, phase
// lengths derived from word/cycle counts.
module tb_tcu_job_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            tcu_val_input;
  logic [DW-1:0]   tcu_data;
  logic            tcu_shift_out;
  logic [DW-1:0]   tcu_out_data;
  logic            resp_valid;
  logic [DW-1:0]   resp_data;
  logic [1:0]      resp_id;
  logic [N-1:0]    done;
  logic            busy;

  tcu_job_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_data(req_data),
    .grant(grant), .tcu_val_input(tcu_val_input), .tcu_data(tcu_data),
    .tcu_shift_out(tcu_shift_out), .tcu_out_data(tcu_out_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int vmode;      // 0 continuous, 1 every other cycle (first low), 2 random
    int smode;      // 0 continuous, 1 random
    bit spur;       // random tcu_shift_out during LOAD/COMPUTE
    bit drop;       // owner drops req once granted
    bit noise;      // non-owners toggle req mid-job
    int exp_owner;  // -1: take it from the round-robin model
    int exp_load;   // -1: not checked
    int exp_total;  // -1: not checked
  } job_vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int last_owner = N - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester after the last owner, cyclically.
  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_owner + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {grant, busy, tcu_val_input, tcu_data, resp_valid, resp_data, resp_id, done}, 64'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req           = '0;
    req_valid     = 4'($urandom);
    tcu_shift_out = 1'($urandom);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_grant", 64'(grant), 64'd0);
    check("idle_outs", {tcu_val_input, resp_valid, done}, 64'd0);
  endtask

  task automatic run_job(input job_vec_t v);
    int owner, phase, loaded, comp, drained, load_len, cyc, n_val, n_resp, n_done;
    logic [3:0]    r;
    logic          sh;
    logic [DW-1:0] own_word;
    owner = (v.exp_owner >= 0) ? v.exp_owner : rr_pick(v.req);
    phase = 0; loaded = 0; comp = 0; drained = 0; load_len = 0;
    cyc = 0; n_val = 0; n_resp = 0; n_done = 0;
    while (phase != 5 && cyc < 2000) begin
      @(negedge clk);
      r = v.req;
      if (phase > 0 && v.drop) r[owner] = 1'b0;
      if (phase > 0 && phase < 4 && v.noise)
        r = r | (4'($urandom_range(0, 15)) & ~(4'b0001 << owner));
      req          = r;
      req_valid    = 4'($urandom);
      req_data     = $urandom;
      tcu_out_data = 8'($urandom);
      if (phase == 1) begin
        case (v.vmode)
          0:       req_valid[owner] = 1'b1;
          1:       req_valid[owner] = (load_len % 2 == 1);
          default: req_valid[owner] = ($urandom_range(0, 3) != 0);
        endcase
      end
      sh = 1'($urandom);
      if (phase == 3)                 sh = (v.smode == 0) ? 1'b1 : 1'($urandom);
      else if (phase == 1 || phase == 2) sh = v.spur ? 1'($urandom) : 1'b0;
      tcu_shift_out = sh;
      #1;
      own_word = req_data[owner*DW +: DW];
      check("grant", 64'(grant), (phase == 0) ? 64'd0 : (64'd1 << owner));
      check("busy", 64'(busy), 64'(phase != 0));
      check("tcu_val_input", 64'(tcu_val_input), 64'(phase == 1 && req_valid[owner]));
      check("tcu_data", 64'(tcu_data), (phase == 1) ? 64'(own_word) : 64'd0);
      check("resp_valid", 64'(resp_valid), 64'(phase == 3 && sh));
      if (phase == 3 && sh) begin
        check("resp_data", 64'(resp_data), 64'(tcu_out_data));
        check("resp_id", 64'(resp_id), 64'(owner));
      end
      check("done", 64'(done), (phase == 4) ? (64'd1 << owner) : 64'd0);
      n_val  += int'(tcu_val_input);
      n_resp += int'(resp_valid);
      n_done += int'(done != 0);
      cyc++;
      case (phase)
        0: phase = 1;
        1: begin
          load_len++;
          if (req_valid[owner]) loaded++;
          if (loaded == 48) phase = 2;
        end
        2: begin
          comp++;
          if (comp == 33) phase = 3;
        end
        3: begin
          if (sh) drained++;
          if (drained == 16) phase = 4;
        end
        default: phase = 5;
      endcase
    end
    check("job_budget", 64'(phase), 64'd5);
    last_owner = owner;
    check("val_beats", 64'(n_val), 64'd48);
    check("resp_beats", 64'(n_resp), 64'd16);
    check("done_pulses", 64'(n_done), 64'd1);
    if (v.exp_load > 0)  check("load_len", 64'(load_len), 64'(v.exp_load));
    if (v.exp_total > 0) check("job_cycles", 64'(cyc), 64'(v.exp_total));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    req  = '0;
    rst  = 1'b1;
    last_owner = N - 1;
  endtask

  job_vec_t tbl[5];

  initial begin
    // req_mask  vmode smode spur drop noise owner load total
    tbl[0] = '{4'b0100, 0, 0, 1'b0, 1'b0, 1'b0,  2, 48,  99};
    tbl[1] = '{4'b0001, 1, 0, 1'b0, 1'b0, 1'b0,  0, 96, 147};
    tbl[2] = '{4'b1010, 0, 0, 1'b1, 1'b0, 1'b0,  1, 48,  99};
    tbl[3] = '{4'b1001, 0, 1, 1'b0, 1'b1, 1'b1,  3, 48,  -1};
    tbl[4] = '{4'b1111, 2, 1, 1'b1, 1'b0, 1'b1,  0, -1,  -1};

    rst = 1'b0; req = '0; req_valid = '0; req_data = '0;
    tcu_shift_out = 1'b0; tcu_out_data = '0;
    #1 check_all_zero("reset_state");
    req_valid = '1; tcu_shift_out = 1'b1; req = 4'b0110;
    #1 check_all_zero("reset_state_driven");
    repeat (2) @(negedge clk);
    req = '0;
    rst = 1'b1;

    // Table-driven jobs.
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      run_job(tbl[i]);
    end

    // Randomized jobs with owner taken from the round-robin model.
    for (int i = 0; i < 6; i++) begin
      job_vec_t v;
      v.req       = 4'($urandom_range(1, 15));
      v.vmode     = $urandom_range(0, 2);
      v.smode     = $urandom_range(0, 1);
      v.spur      = 1'($urandom);
      v.drop      = 1'($urandom);
      v.noise     = 1'($urandom);
      v.exp_owner = -1;
      v.exp_load  = -1;
      v.exp_total = -1;
      idle_cycle();
      run_job(v);
    end

    // Reset in the middle of LOAD, after 20 words: job dropped, no done.
    idle_cycle();
    @(negedge clk);
    req = 4'b0010; req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      req_data  = $urandom;
      #1;
      check("abort_grant", 64'(grant), 64'b0010);
      check("abort_val", 64'(tcu_val_input), 64'd1);
      check("abort_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    tcu_shift_out = 1'b1;
    #2 rst = 1'b0;
    #1 check_all_zero("abort_reset_async");
    @(negedge clk);
    #1 check_all_zero("abort_reset_held");
    req = '0;
    rst = 1'b1;
    last_owner = N - 1;
    idle_cycle();
    run_job('{4'b0010, 0, 0, 1'b0, 1'b0, 1'b0, 1, 48, 99});

    // Contention with req held high: back-to-back grants 0,1,3,0.
    pulse_reset();
    run_job('{4'b1011, 0, 0, 1'b0, 1'b0, 1'b0, 0, 48, 99});
    run_job('{4'b1011, 0, 0, 1'b0, 1'b0, 1'b0, 1, 48, 99});
    run_job('{4'b1011, 0, 0, 1'b0, 1'b0, 1'b0, 3, 48, 99});
    run_job('{4'b1011, 0, 0, 1'b0, 1'b0, 1'b0, 0, 48, 99});
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
